dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-port arbiter that shares the single-ported, word-addressed data memory between the CPU load/store path (port 0) and the debug/loader port (port 1). It sits between both requesters and the data memory, serialises their accesses through a three-state sequencer, and returns registered read data with a one-cycle acknowledge. Fairness between the ports is round-robin by default.

## Interface
Parameters:
- AW, 5: word-address width; memory depth is 2^AW words.
- DW, 32: data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- req0, req1  in  1  access request per port; held high until that port's ack.
- we0, we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0, addr1  in  32  byte address; stable while req is high.
- wdata0, wdata1  in  DW  write data; stable while req is high.
- ack0, ack1  out  1  one-cycle completion pulse for the port.
- err0, err1  out  1  valid with ack; 1 = access rejected.
- rdata  out  DW  read data; valid when either ack is high.
- mem_addr  out  AW  word index to the memory.
- mem_wdata  out  DW  write data to the memory.
- mem_we  out  1  memory write strobe; the memory writes on the clk edge.
- mem_rdata  in  DW  combinational memory read data for mem_addr.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset value: IDLE.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise select a winner. Latch its we, addr, wdata and a port id into holding registers, flip the round-robin pointer, and go to ACCESS.
- Round-robin selection:
  - Only one req high: that port wins.
  - Both high: the port named by the pointer wins.
  - The pointer resets to 0 and, after each grant, points to the loser.
- Error check, on the latched address: err = (addr[1:0] != 0) or (addr[31:AW+2] != 0).
- ACCESS:
  - mem_addr = latched addr[AW+1:2].
  - mem_wdata = latched wdata.
  - mem_we = latched we and not err.
  - At the edge, capture mem_rdata into rdata (reads only; rdata is held on writes and on errors) and go to RESP.
- RESP:
  - Assert ack of the latched port for exactly one cycle, with err of that port.
  - Unconditionally return to IDLE.
- A requester must drop req in the cycle after ack; a req still high in IDLE is treated as a new request.
- Reset values, including reset mid-operation:
  - ack0, ack1, err0, err1, mem_we: 0.
  - rdata, mem_addr, mem_wdata, holding registers: 0.
  - Pointer: 0.
  - An in-flight write is aborted and no ack is issued.

## Timing
- Latency: req sampled high at edge N, memory access during cycle N..N+1, ack high during cycle N+2..N+3.
- Throughput: at most one access per 3 cycles.
- mem_we is high for exactly one cycle per accepted write and never while in IDLE or RESP.
- Simultaneous requests: the loser waits in IDLE for the next arbitration, at the earliest 3 cycles after the winner was latched.
- ack0 and ack1 are never high in the same cycle.

## Configuration
- DM_ARB_FIXED_PRIO_EN defined: fixed priority. Port 0 always wins when both req are high; the pointer is removed and port 1 can starve.
- DM_ARB_FIXED_PRIO_EN undefined: round-robin as in Operation.

## Test plan
- Reset, then port 0 writes addr 0x08, data 0xDEADBEEF:
  - mem_we pulses once with mem_addr = 2.
  - ack0 is high 2 cycles after the request is sampled, with err0 = 0.
  - A following port 1 read of 0x08 returns rdata = 0xDEADBEEF.
- req0 and req1 both held continuously with reads of 0x00 and 0x04:
  - Grants alternate 0, 1, 0, 1, one ack every 3 cycles.
  - With DM_ARB_FIXED_PRIO_EN and req0 re-raised each time, only ack0 occurs.
- Port 1 write to 0x0000_0006 (misaligned) and to 0x0000_0080 (out of range):
  - ack1 with err1 = 1.
  - mem_we stays 0.
  - Memory contents are unchanged.
- rst_n asserted while in ACCESS of a write:
  - All outputs go to 0 immediately and the FSM is IDLE.
  - No ack is issued.
  - The pointer returns to 0.
- Port 0 holds req0 high for one extra cycle after ack0: a second, identical access is performed and a second ack0 follows 3 cycles after the first.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one single-ported, word-addressed data memory between
// the CPU load/store path (port 0) and the debug/loader port (port 1).
// A three-state sequencer (IDLE -> ACCESS -> RESP) serialises accesses.
// Read data and the ack/err pulse are registered.
// Optional feature macro: DM_ARB_FIXED_PRIO_EN
//   - defined:   port 0 always wins a tie; port 1 can starve.
//   - undefined: round-robin arbitration.
//
// Handshake: a port raises reqN together with stable weN/addrN/wdataN and
// holds them until it sees ackN. ackN is a single-cycle pulse, and errN is
// valid with it. A req still high in the cycle after ack counts as a new
// request.
module dm_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [31:0]   addr0,
  input  logic [31:0]   addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            hold_we;
  logic            hold_id;
  logic [31:0]     hold_addr;
  logic [DW-1:0]   hold_wdata;
  logic            grant_id;
  logic            start;
  logic            addr_err;

  assign start     = (state == IDLE) && (req0 || req1);
  assign fsm_state = state;

  // Misaligned or beyond the memory depth: the access is rejected.
  assign addr_err  = (hold_addr[1:0] != 2'b00) || (hold_addr[31:AW+2] != '0);
  assign mem_addr  = hold_addr[AW+1:2];
  assign mem_wdata = hold_wdata;

`ifdef DM_ARB_FIXED_PRIO_EN
  // Fixed priority: port 1 wins only when port 0 is not requesting.
  always_comb begin
    grant_id = req1 && !req0;
  end
`else
  logic ptr;

  // Round-robin: on a tie the pointer decides, otherwise the lone requester wins.
  always_comb begin
    grant_id = 1'b0;
    if (req0 && req1) grant_id = ptr;
    else if (req1)    grant_id = 1'b1;
  end

  // After every grant the pointer names the loser, giving it the next tie.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)      ptr <= 1'b0;
    else if (start) ptr <= ~grant_id;
  end
`endif

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and the memory write strobe.
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = ACCESS;
      ACCESS: begin
        mem_we    = hold_we && !addr_err;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's request so the requesters may not be looked at again.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hold_we    <= 1'b0;
      hold_id    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else if (start) begin
      hold_id    <= grant_id;
      hold_we    <= grant_id ? we1    : we0;
      hold_addr  <= grant_id ? addr1  : addr0;
      hold_wdata <= grant_id ? wdata1 : wdata0;
    end
  end

  // Capture read data at the end of ACCESS; writes and errors keep old data.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) rdata <= '0;
    else if (state == ACCESS && !hold_we && !addr_err) rdata <= mem_rdata;
  end

  // One-cycle registered ack/err to the latched port, issued from RESP.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      ack0 <= (state == RESP) && !hold_id;
      ack1 <= (state == RESP) &&  hold_id;
      err0 <= (state == RESP) && !hold_id && addr_err;
      err1 <= (state == RESP) &&  hold_id && addr_err;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed testbench for dm_arbiter (default round-robin build).
module tb_dm_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [31:0]   addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    fsm_state;

  logic          mem_init;
  logic [DW-1:0] mem [0:31];

  int n_checks;
  int n_fail;

  // Scoreboard of expected acks: {port id, rdata} and the cycle it should land on.
  logic [DW:0] exp_q[$];
  int          exp_cyc_q[$];

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .fsm_state(fsm_state)
  );

  // Clock and memory model: word i preloads to 0xA5A5_00ii.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A5_0000 | i;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Single access from one port; the requester drops req as soon as it sees ack.
  // lat counts negedges after req is raised: 1 = cycle after the sampling edge.
  task automatic do_access(input logic port, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output logic got_err,
                           output logic [31:0] got_rdata, output int lat,
                           output int we_cnt, output logic [AW-1:0] we_addr,
                           output int other_ack);
    got_err = 1'b0; got_rdata = '0; lat = 0; we_cnt = 0; we_addr = '0; other_ack = 0;
    @(negedge clk);
    if (!port) begin req0 = 1'b1; we0 = wr; addr0 = a; wdata0 = d; end
    else       begin req1 = 1'b1; we1 = wr; addr1 = a; wdata1 = d; end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_addr = mem_addr; end
      if (port ? ack0 : ack1) other_ack++;
      if (port ? ack1 : ack0) begin
        lat = i;
        got_err = port ? err1 : err0;
        got_rdata = rdata;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  // Both ports request continuously for a window; acks are checked against exp_q.
  task automatic run_both(input logic [31:0] a0, input logic [31:0] a1, input int window);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = a0;
    req1 = 1'b1; we1 = 1'b0; addr1 = a1;
    for (int i = 1; i <= window; i++) begin
      @(negedge clk);
      if (ack0 && ack1) check("dual_ack", 1, 0);
      else if (ack0 || ack1) begin
        if (exp_q.size() == 0) check("extra_ack", {63'd0, ack1}, 64'd2);
        else begin
          check("rr_grant_data", {ack1, rdata}, exp_q.pop_front());
          check("rr_ack_cycle", i, exp_cyc_q.pop_front());
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr_missing_acks", exp_q.size(), 0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  logic          g_err;
  logic [31:0]   g_rdata;
  int            g_lat, g_we_cnt, g_other, acks, first_ack, second_ack;
  logic [AW-1:0] g_we_addr;

  initial begin
    n_checks = 0; n_fail = 0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    mem_init = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; mem_init = 1'b0;

    // Reset values.
    check("rst_state", fsm_state, 0);
    check("rst_ack", {ack0, ack1, err0, err1, mem_we}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);

    // Port 0 write 0x08 <- DEADBEEF.
    do_access(1'b0, 1'b1, 32'h08, 32'hDEAD_BEEF, g_err, g_rdata, g_lat, g_we_cnt, g_we_addr, g_other);
    check("wr_latency", g_lat, 3);
    check("wr_err0", g_err, 0);
    check("wr_we_pulses", g_we_cnt, 1);
    check("wr_mem_addr", g_we_addr, 2);
    check("wr_other_ack", g_other, 0);

    // Port 1 read-back of 0x08.
    do_access(1'b1, 1'b0, 32'h08, 32'h0, g_err, g_rdata, g_lat, g_we_cnt, g_we_addr, g_other);
    check("rd_rdata", g_rdata, 32'hDEAD_BEEF);
    check("rd_err1", g_err, 0);
    check("rd_latency", g_lat, 3);
    check("rd_we_pulses", g_we_cnt, 0);

    // Rejected writes: misaligned, then beyond the memory depth.
    do_access(1'b1, 1'b1, 32'h06, 32'h1111_1111, g_err, g_rdata, g_lat, g_we_cnt, g_we_addr, g_other);
    check("mis_err1", g_err, 1);
    check("mis_latency", g_lat, 3);
    check("mis_we_pulses", g_we_cnt, 0);
    check("mis_rdata_held", g_rdata, 32'hDEAD_BEEF);
    do_access(1'b1, 1'b1, 32'h80, 32'h2222_2222, g_err, g_rdata, g_lat, g_we_cnt, g_we_addr, g_other);
    check("oor_err1", g_err, 1);
    check("oor_we_pulses", g_we_cnt, 0);
    do_access(1'b0, 1'b0, 32'h04, 32'h0, g_err, g_rdata, g_lat, g_we_cnt, g_we_addr, g_other);
    check("mis_word1_kept", g_rdata, 32'hA5A5_0001);
    do_access(1'b0, 1'b0, 32'h00, 32'h0, g_err, g_rdata, g_lat, g_we_cnt, g_we_addr, g_other);
    check("oor_word0_kept", g_rdata, 32'hA5A5_0000);

    // Fresh reset so the pointer is 0, then both ports request continuously.
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    exp_q.push_back({1'b0, 32'hA5A5_0000}); exp_cyc_q.push_back(3);
    exp_q.push_back({1'b1, 32'hA5A5_0001}); exp_cyc_q.push_back(6);
    exp_q.push_back({1'b0, 32'hA5A5_0000}); exp_cyc_q.push_back(9);
    exp_q.push_back({1'b1, 32'hA5A5_0001}); exp_cyc_q.push_back(12);
    run_both(32'h00, 32'h04, 12);
    repeat (2) @(negedge clk);

    // Port 0 access leaves the pointer at 1; then reset in ACCESS of a port 1 write.
    do_access(1'b0, 1'b0, 32'h00, 32'h0, g_err, g_rdata, g_lat, g_we_cnt, g_we_addr, g_other);
    check("pre_rst_ack", g_lat, 3);
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0C; wdata1 = 32'h1234_5678;
    @(negedge clk);
    check("mid_we_before_rst", mem_we, 1);
    rst_n = 1'b1; req1 = 1'b0; we1 = 1'b0;
    #1;
    check("mid_rst_state", fsm_state, 0);
    check("mid_rst_outs", {ack0, ack1, err0, err1, mem_we}, 0);
    check("mid_rst_bus", {rdata, 27'd0, mem_addr}, 0);
    check("mid_rst_wdata", mem_wdata, 0);
    @(negedge clk); rst_n = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    check("mid_rst_no_ack", acks, 0);
    do_access(1'b0, 1'b0, 32'h0C, 32'h0, g_err, g_rdata, g_lat, g_we_cnt, g_we_addr, g_other);
    check("mid_rst_word3_kept", g_rdata, 32'hA5A5_0003);
    // Pointer back at 0 after reset: that read moved it to 1, so reset again.
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    exp_q.push_back({1'b0, 32'hA5A5_0000}); exp_cyc_q.push_back(3);
    exp_q.push_back({1'b1, 32'hA5A5_0001}); exp_cyc_q.push_back(6);
    run_both(32'h00, 32'h04, 6);
    repeat (2) @(negedge clk);

    // Port 0 holds req0 one extra cycle after ack0: a second identical access follows.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h08;
    first_ack = 0; second_ack = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack1) check("hold_ack1", 1, 0);
      if (ack0) begin
        if (first_ack == 0) begin
          first_ack = i;
          check("hold_rdata1", rdata, 32'hDEAD_BEEF);
        end else if (second_ack == 0) begin
          second_ack = i;
          check("hold_rdata2", rdata, 32'hDEAD_BEEF);
        end
      end
      // Keep req0 through the ack cycle, drop it one cycle later.
      if (first_ack != 0 && i == first_ack + 1) req0 = 1'b0;
      if (second_ack != 0) req0 = 1'b0;
    end
    req0 = 1'b0;
    check("hold_first_ack", first_ack, 3);
    check("hold_second_ack", second_ack, 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
